// File: rtl/paddle_draw_pipe.sv
// Paddle position keeper and pixel classifier for the pong core.
// Keeps the top row of up to two paddles, moves them once per frame from
// the player inputs (clamped to the screen), and tells the colour mux after
// a fixed latency whether the current pixel lies on a paddle.
module paddle_draw_pipe #(
  parameter int NUM_PLAYERS     = 2,
  parameter int H_CNT_WID       = 10,
  parameter int V_CNT_WID       = 10,
  parameter int SCREEN_W        = 640,
  parameter int SCREEN_H        = 480,
  parameter int PLAYER_WID      = 8,
  parameter int PLAYER_HEIGHT   = 64,
  parameter int PLAYER_STEP     = 4,
  parameter int PIPELINE_STAGES = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic [H_CNT_WID-1:0]             i_drawX,
  input  logic [V_CNT_WID-1:0]             i_drawY,
  input  logic                             i_pixelValid,
  input  logic                             i_frameStart,
  input  logic                             i_freeze,
  input  logic [NUM_PLAYERS-1:0]           i_moveUp,
  input  logic [NUM_PLAYERS-1:0]           i_moveDown,
  output logic                             o_isPlayerPos,
  output logic                             o_playerIdx,
  output logic                             o_hitValid,
  output logic [NUM_PLAYERS*V_CNT_WID-1:0] o_paddleY
);

  // One extra bit on every vertical/horizontal quantity so that clamping
  // and range checks can never wrap around.
  localparam int                 Y_MAX_I       = SCREEN_H - PLAYER_HEIGHT;
  localparam logic [V_CNT_WID:0] C_Y_MAX       = (V_CNT_WID+1)'(Y_MAX_I);
  localparam logic [V_CNT_WID:0] C_Y_INIT      = (V_CNT_WID+1)'(Y_MAX_I / 2);
  localparam logic [V_CNT_WID:0] C_STEP        = (V_CNT_WID+1)'(PLAYER_STEP);
  localparam logic [V_CNT_WID:0] C_HEIGHT      = (V_CNT_WID+1)'(PLAYER_HEIGHT);
  localparam logic [H_CNT_WID:0] C_LEFT_END    = (H_CNT_WID+1)'(PLAYER_WID);
  localparam logic [H_CNT_WID:0] C_RIGHT_START = (H_CNT_WID+1)'(SCREEN_W - PLAYER_WID);

  logic [H_CNT_WID:0]   w_xWide;
  logic [V_CNT_WID:0]   w_yPixWide;
  logic [NUM_PLAYERS-1:0] w_hit;

  assign w_xWide    = {1'b0, i_drawX};
  assign w_yPixWide = {1'b0, i_drawY};

  genvar p;
  generate
    for (p = 0; p < NUM_PLAYERS; p++) begin : g_player
      logic [V_CNT_WID-1:0] r_y;
      logic [V_CNT_WID-1:0] w_yNext;
      logic [V_CNT_WID:0]   w_yWide;
      logic [V_CNT_WID:0]   w_yUp;
      logic [V_CNT_WID:0]   w_yDown;
      logic [V_CNT_WID:0]   w_yEnd;
      logic                 w_colHit;
      logic                 w_rowHit;

      assign w_yWide = {1'b0, r_y};
      assign w_yUp   = w_yWide - C_STEP;
      assign w_yDown = w_yWide + C_STEP;
      assign w_yEnd  = w_yWide + C_HEIGHT;

      // Candidate position after one move step, clamped to the screen edges.
      always_comb begin
        w_yNext = r_y;
        if (i_moveUp[p] && !i_moveDown[p]) begin
          if (w_yWide < C_STEP) begin
            w_yNext = '0;
          end else begin
            w_yNext = w_yUp[V_CNT_WID-1:0];
          end
        end else if (i_moveDown[p] && !i_moveUp[p]) begin
          if (w_yDown > C_Y_MAX) begin
            w_yNext = C_Y_MAX[V_CNT_WID-1:0];
          end else begin
            w_yNext = w_yDown[V_CNT_WID-1:0];
          end
        end
      end

      // Commit the move only on an unfrozen frame start; reset recentres.
      always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
          r_y <= C_Y_INIT[V_CNT_WID-1:0];
        end else if (i_frameStart && !i_freeze) begin
          r_y <= w_yNext;
        end
      end

      assign w_rowHit = (w_yPixWide >= w_yWide) && (w_yPixWide < w_yEnd);

      if (p == 0) begin : g_left
        assign w_colHit = (w_xWide < C_LEFT_END);
      end else begin : g_right
        assign w_colHit = (w_xWide >= C_RIGHT_START);
      end

      assign w_hit[p] = w_colHit & w_rowHit & i_pixelValid;
      assign o_paddleY[p*V_CNT_WID +: V_CNT_WID] = r_y;
    end
  endgenerate

  logic                   r_pipeValid [PIPELINE_STAGES];
  logic [NUM_PLAYERS-1:0] r_pipeHit   [PIPELINE_STAGES];
  logic [NUM_PLAYERS-1:0] w_outHit;

  // Stage 0 captures the compare results; later stages are a plain delay line.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      for (int s = 0; s < PIPELINE_STAGES; s++) begin
        r_pipeValid[s] <= 1'b0;
        r_pipeHit[s]   <= '0;
      end
    end else begin
      r_pipeValid[0] <= i_pixelValid;
      r_pipeHit[0]   <= w_hit;
      for (int s = 1; s < PIPELINE_STAGES; s++) begin
        r_pipeValid[s] <= r_pipeValid[s-1];
        r_pipeHit[s]   <= r_pipeHit[s-1];
      end
    end
  end

  assign w_outHit      = r_pipeHit[PIPELINE_STAGES-1];
  assign o_hitValid    = r_pipeValid[PIPELINE_STAGES-1];
  assign o_isPlayerPos = |w_outHit;

  generate
    if (NUM_PLAYERS == 1) begin : g_idxSingle
      assign o_playerIdx = 1'b0;
    end else begin : g_idxDual
      assign o_playerIdx = ~w_outHit[0] & w_outHit[1];
    end
  endgenerate

endmodule

// File: tb/tb_paddle_draw_pipe.sv
// Self-checking bench for paddle_draw_pipe: three instances (default,
// single-stage, four-stage single-player) share one stimulus stream and are
// compared against a small position model through per-instance queues.
module tb_paddle_draw_pipe;

  logic       clk;
  logic       rstN;
  logic [9:0] drawX;
  logic [9:0] drawY;
  logic       pixelValid;
  logic       frameStart;
  logic       freeze;
  logic [1:0] moveUp;
  logic [1:0] moveDown;

  logic       aPos, aIdx, aHv;
  logic [19:0] aPy;
  logic       bPos, bIdx, bHv;
  logic [19:0] bPy;
  logic       cPos, cIdx, cHv;
  logic [9:0] cPy;

  int totalCnt;
  int badCnt;
  int modelY0;
  int modelY1;

  logic [2:0] qA[$];
  logic [2:0] qB[$];
  logic [2:0] qC[$];

  paddle_draw_pipe dutA (
    .i_clk(clk), .i_rst_n(rstN), .i_drawX(drawX), .i_drawY(drawY),
    .i_pixelValid(pixelValid), .i_frameStart(frameStart), .i_freeze(freeze),
    .i_moveUp(moveUp), .i_moveDown(moveDown),
    .o_isPlayerPos(aPos), .o_playerIdx(aIdx), .o_hitValid(aHv), .o_paddleY(aPy)
  );

  paddle_draw_pipe #(.PIPELINE_STAGES(1)) dutB (
    .i_clk(clk), .i_rst_n(rstN), .i_drawX(drawX), .i_drawY(drawY),
    .i_pixelValid(pixelValid), .i_frameStart(frameStart), .i_freeze(freeze),
    .i_moveUp(moveUp), .i_moveDown(moveDown),
    .o_isPlayerPos(bPos), .o_playerIdx(bIdx), .o_hitValid(bHv), .o_paddleY(bPy)
  );

  paddle_draw_pipe #(.NUM_PLAYERS(1), .PIPELINE_STAGES(4)) dutC (
    .i_clk(clk), .i_rst_n(rstN), .i_drawX(drawX), .i_drawY(drawY),
    .i_pixelValid(pixelValid), .i_frameStart(frameStart), .i_freeze(freeze),
    .i_moveUp(moveUp[0:0]), .i_moveDown(moveDown[0:0]),
    .o_isPlayerPos(cPos), .o_playerIdx(cIdx), .o_hitValid(cHv), .o_paddleY(cPy)
  );

  // Free-running pixel clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    totalCnt++;
    if (observed !== expected) begin
      badCnt++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, observed, expected);
    end
  endtask

  // Expected {hitValid, isPlayerPos, playerIdx} from the current model position.
  function automatic logic [2:0] calcExp(input int x, input int y, input bit v, input int np);
    bit h0;
    bit h1;
    h0 = v && (x < 8) && (y >= modelY0) && (y < modelY0 + 64);
    h1 = v && (np == 2) && (x >= 632) && (y >= modelY1) && (y < modelY1 + 64);
    return {v, h0 | h1, (!h0) && h1};
  endfunction

  function automatic int stepY(input int y, input bit up, input bit dn);
    if (up && !dn) return (y < 4) ? 0 : y - 4;
    if (dn && !up) return (y + 4 > 416) ? 416 : y + 4;
    return y;
  endfunction

  task automatic popCheck(input string name, inout logic [2:0] q[$], input int lat,
                          input logic hv, input logic pos, input logic idx);
    logic [2:0] e;
    if (q.size() >= lat) begin
      e = q.pop_front();
      checkOutput({name, "_hitValid"}, int'(hv), int'(e[2]));
      checkOutput({name, "_isPlayerPos"}, int'(pos), int'(e[1]));
      checkOutput({name, "_playerIdx"}, int'(idx), int'(e[0]));
    end
  endtask

  // Drive one cycle of inputs, push expectations, then check after the edge.
  task automatic applyStimulus(input int x, input int y, input bit v, input bit fs,
                               input bit frz, input bit [1:0] up, input bit [1:0] dn,
                               input bit rst);
    drawX      = 10'(x);
    drawY      = 10'(y);
    pixelValid = v;
    frameStart = fs;
    freeze     = frz;
    moveUp     = up;
    moveDown   = dn;
    rstN       = rst;
    if (!rst) begin
      qA.delete();
      qB.delete();
      qC.delete();
      repeat (2) qA.push_back(3'b000);
      repeat (1) qB.push_back(3'b000);
      repeat (4) qC.push_back(3'b000);
      modelY0 = 208;
      modelY1 = 208;
    end else begin
      qA.push_back(calcExp(x, y, v, 2));
      qB.push_back(calcExp(x, y, v, 2));
      qC.push_back(calcExp(x, y, v, 1));
      if (fs && !frz) begin
        modelY0 = stepY(modelY0, up[0], dn[0]);
        modelY1 = stepY(modelY1, up[1], dn[1]);
      end
    end
    @(posedge clk);
    #1;
    popCheck("A", qA, 2, aHv, aPos, aIdx);
    popCheck("B", qB, 1, bHv, bPos, bIdx);
    popCheck("C", qC, 4, cHv, cPos, cIdx);
    checkOutput("A_paddleY0", int'(aPy[9:0]), modelY0);
    checkOutput("A_paddleY1", int'(aPy[19:10]), modelY1);
    checkOutput("B_paddleY0", int'(bPy[9:0]), modelY0);
    checkOutput("B_paddleY1", int'(bPy[19:10]), modelY1);
    checkOutput("C_paddleY0", int'(cPy), modelY0);
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
  endtask

  task automatic randomCycle(input bit allowMoves);
    int sel;
    int x;
    sel = $urandom_range(0, 2);
    if (sel == 0) x = $urandom_range(0, 15);
    else if (sel == 1) x = $urandom_range(624, 639);
    else x = $urandom_range(0, 639);
    applyStimulus(x, $urandom_range(0, 479), $urandom_range(0, 3) != 0,
                  allowMoves && ($urandom_range(0, 3) == 0), $urandom_range(0, 3) == 0,
                  2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b1);
  endtask

  initial begin
    totalCnt   = 0;
    badCnt     = 0;
    modelY0    = 208;
    modelY1    = 208;
    rstN       = 1'b0;
    drawX      = '0;
    drawY      = '0;
    pixelValid = 1'b0;
    frameStart = 1'b0;
    freeze     = 1'b0;
    moveUp     = '0;
    moveDown   = '0;

    // Reset held with a paddle pixel on the inputs: outputs must stay low.
    repeat (3) applyStimulus(3, 210, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0);
    idle(4);

    // Single pixels on both paddles and just past the bottom of paddle 1.
    applyStimulus(3, 210, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    applyStimulus(636, 271, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    applyStimulus(636, 272, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    applyStimulus(7, 207, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    applyStimulus(8, 210, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    applyStimulus(631, 240, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    applyStimulus(632, 208, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    idle(4);

    // Paddle 0 up to the top edge, paddle 1 down to the bottom edge.
    for (int i = 0; i < 60; i++) begin
      applyStimulus(0, 0, 1'b0, 1'b1, 1'b0, 2'b01, 2'b10, 1'b1);
      applyStimulus(2, modelY0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
      applyStimulus(635, modelY1 + 63, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
      applyStimulus(639, modelY1 + 64, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    end
    idle(4);

    // Conflicting requests, then freeze: positions must hold.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1, 10, 1'b1, 1'b1, 1'b0, 2'b11, 2'b11, 1'b1);
      idle(1);
    end
    for (int i = 0; i < 5; i++) begin
      applyStimulus(637, 420, 1'b1, 1'b1, 1'b1, 2'b10, 2'b01, 1'b1);
      idle(1);
    end
    idle(4);

    // Frame start and a pixel in the same cycle use the old position.
    applyStimulus(0, 0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0);
    applyStimulus(0, 208, 1'b1, 1'b1, 1'b0, 2'b00, 2'b01, 1'b1);
    applyStimulus(0, 208, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    applyStimulus(0, 212, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1);
    idle(4);

    // Reset pulse in the middle of a busy stream.
    for (int i = 0; i < 20; i++) randomCycle(1'b1);
    applyStimulus(3, 210, 1'b1, 1'b1, 1'b0, 2'b00, 2'b11, 1'b0);
    for (int i = 0; i < 20; i++) randomCycle(1'b1);

    // Long random run.
    for (int i = 0; i < 400; i++) randomCycle(1'b1);
    idle(5);

    $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
    $finish;
  end

endmodule
